lsu_mem_stage: RTL and testbench
================================

# lsu_mem_stage

Parametrised memory-stage load/store unit for the RISC-V pipeline, sitting between EX and WB. It extends the combinational byte-select/writeback path to a variable-latency data memory with a request/grant/response handshake. It supports XLEN of 32 or 64, splits boundary-crossing (misaligned) accesses into two aligned beats, and back-pressures the pipeline with a stall while a memory access is in flight.

## Interface
- XLEN, 32, datapath width; legal values are 32 and 64. NB = XLEN/8.
- ADDR_W, 32, byte-address width.
- SPLIT_MISALIGNED, 1, 1 = split boundary-crossing accesses into two beats; 0 = fault on them.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  EX presents an operation.
- req_ready_o  out  1  unit can accept; high only in IDLE.
- is_load_i / is_store_i  in  1  operation class; both 0 = non-memory pass-through.
- size_i  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- unsigned_i  in  1  zero-extend loads.
- aluout_i  in  XLEN  address for memory operations, result for non-memory operations.
- data2_i  in  XLEN  store data.
- wa_i  in  5  writeback register index.
- we_i  in  1  register-file write enable.
- stall_o  out  1  high while a memory operation is in flight (= !req_ready_o).
- wb_valid_o  out  1  one-cycle pulse; writeback fields valid.
- wa_o  out  5  registered writeback index.
- we_o  out  1  registered write enable; forced to 0 on fault.
- wdata_o  out  XLEN  writeback data.
- fault_o  out  1  misaligned (SPLIT_MISALIGNED=0) or illegal size; qualified by wb_valid_o.
- dmem_req_o  out  1  memory request.
- dmem_gnt_i  in  1  request accepted this cycle.
- dmem_addr_o  out  ADDR_W  NB-aligned beat address.
- dmem_we_o  out  NB  byte write strobes; all 0 for loads.
- dmem_wdata_o  out  XLEN  lane-aligned store data.
- dmem_rvalid_i  in  1  load beat response.
- dmem_rdata_i  in  XLEN  load beat data.

## Operation
- States: IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, RESP.
- Accept when req_valid_i & req_ready_o. Latch all inputs; compute off = addr[log2(NB)-1:0] and bytes = 1<<size_i.
- Illegal size: size_i=3 with XLEN=32. Go to RESP with fault_o=1 and we_o=0; no memory access.
- Non-memory op: go to RESP with wdata_o = aluout_i.
- Crossing: off+bytes > NB.
  - SPLIT_MISALIGNED=0: fault, handled as for illegal size.
  - Otherwise: two beats.
- Beat addressing:
  - mask = ((1<<bytes)-1) << off, computed over 2·NB bits.
  - Lo beat: address addr & ~(NB-1), strobes mask[NB-1:0].
  - Hi beat: lo address + NB, strobes mask[2NB-1:NB].
  - Store data is shifted left by 8·off over 2·XLEN bits, then split the same way.
- State transitions:
  - REQ_x holds dmem_req_o and the beat fields stable until dmem_gnt_i.
  - Store: grant completes the beat. Go to REQ_HI if a hi beat is needed, else RESP.
  - Load: grant moves to WAIT_x. dmem_rvalid_i captures the beat, then go to REQ_HI or RESP.
- Load assembly: {hi_rdata, lo_rdata} >> 8·off, truncate to bytes, sign-extend unless unsigned_i. The hi beat counts as zero when unused.
- RESP: pulse wb_valid_o and return to IDLE.
- dmem_rvalid_i outside WAIT_x is ignored.
- At most one beat is outstanding at any time.

## Timing
- Reset values: state IDLE; req_ready_o=1; stall_o=0; wb_valid_o=0; fault_o=0; we_o=0; wa_o=0; wdata_o=0; dmem_req_o=0; dmem_we_o=0; dmem_addr_o=0; dmem_wdata_o=0.
- Accept at cycle T: dmem_req_o rises at T+1.
- Zero-wait memory (grant at T+1, rvalid at T+2): aligned load wb_valid_o at T+3; aligned store wb_valid_o at T+2.
- Each extra beat adds the same sequence again.
- Non-memory op or fault: wb_valid_o at T+1.
- req_ready_o returns high in the cycle after the wb_valid_o pulse.
- rst asserted in any state: IDLE at the next edge, all outputs at reset values, no wb_valid_o for the aborted operation. A late rvalid is ignored.
- Grant and rvalid in the same cycle are not legal. The response arrives at least one cycle after the grant.

## Test plan
- XLEN=32, LW 0x100, rdata 0xDEADBEEF -> dmem_we_o=0000, wdata_o=0xDEADBEEF, wb_valid_o one cycle after rvalid.
- LB 0x103, rdata 0x80112233 -> wdata_o=0xFFFFFF80. Same with LBU -> 0x00000080.
- SH 0x102, data 0x0000ABCD -> single beat at addr 0x100, we=1100, wdata=0xABCD0000.
- Misaligned LW 0x103:
  - Beats at 0x100 and 0x104, rdata 0x44332211 then 0x88776655 -> wdata_o=0x77665544.
  - Repeat with SPLIT_MISALIGNED=0 -> fault_o=1, we_o=0, no dmem_req_o.
- Misaligned SW 0x0FE, data 0x11223344 with a 3-cycle grant delay per beat:
  - Lo beat: 0x0FC, we=1100, wdata=0x33440000.
  - Hi beat: 0x100, we=0011, wdata=0x00001122.
  - stall_o stays high throughout.
- rst during WAIT_LO:
  - Next cycle: dmem_req_o=0, stall_o=0, req_ready_o=1.
  - A subsequent stray rvalid produces no wb_valid_o.
  - A new LW completes normally.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: memory-stage load/store unit between EX and WB.
// Drives a variable-latency data memory over a req/gnt/rvalid handshake. An access that crosses
// an NB-byte boundary is either split into two aligned beats or faulted, depending on
// SPLIT_MISALIGNED. The pipeline is stalled while an access is in flight.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   req_valid_i / req_ready_o   EX handshake; ready only when idle
//   is_load_i, is_store_i       operation class; neither set means a pass-through result
//   size_i, unsigned_i          access size (log2 bytes) and load zero-extension
//   aluout_i, data2_i           address (or pass-through result) and store data
//   wa_i, we_i                  writeback register index and write enable
//   stall_o                     high while an operation is in flight
//   wb_valid_o, wa_o, we_o,
//   wdata_o, fault_o            one-cycle writeback pulse and its fields
//   dmem_*                      data-memory beat request, strobes, store data and load response
module lsu_mem_stage #(
  parameter int unsigned XLEN             = 32,
  parameter int unsigned ADDR_W           = 32,
  parameter bit          SPLIT_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [XLEN-1:0]   aluout_i,
  input  logic [XLEN-1:0]   data2_i,
  input  logic [4:0]        wa_i,
  input  logic              we_i,
  output logic              stall_o,
  output logic              wb_valid_o,
  output logic [4:0]        wa_o,
  output logic              we_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic              fault_o,
  output logic              dmem_req_o,
  input  logic              dmem_gnt_i,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [XLEN/8-1:0] dmem_we_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQ_LO  = 3'd1;
  localparam logic [2:0] WAIT_LO = 3'd2;
  localparam logic [2:0] REQ_HI  = 3'd3;
  localparam logic [2:0] WAIT_HI = 3'd4;
  localparam logic [2:0] RESP    = 3'd5;

  localparam logic [2*NB-1:0] MASK_ONE = {{(2*NB-1){1'b0}}, 1'b1};

  logic [2:0]      r_state;
  logic            r_load;
  logic            r_store;
  logic [1:0]      r_size;
  logic            r_unsigned;
  logic [XLEN-1:0] r_alu;
  logic [XLEN-1:0] r_data2;
  logic [4:0]      r_wa;
  logic            r_we;
  logic            r_fault;
  logic            r_need_hi;
  logic [XLEN-1:0] r_lo_rdata;
  logic [XLEN-1:0] r_hi_rdata;

  // Decode of the incoming request, used only at accept time.
  logic [OFFW-1:0] w_in_off;
  logic [3:0]      w_in_bytes;
  logic [4:0]      w_in_end;
  logic            w_in_cross;
  logic            w_in_illegal;
  logic            w_in_mem;
  logic            w_in_fault;

  assign w_in_off     = aluout_i[OFFW-1:0];
  assign w_in_bytes   = 4'd1 << size_i;
  assign w_in_end     = 5'(w_in_off) + 5'(w_in_bytes);
  assign w_in_cross   = w_in_end > 5'(NB);
  assign w_in_illegal = (XLEN == 32) && (size_i == 2'd3);
  assign w_in_mem     = is_load_i | is_store_i;
  assign w_in_fault   = w_in_mem & (w_in_illegal | (w_in_cross & !SPLIT_MISALIGNED));

  // Beat geometry from the latched operation.
  logic [OFFW-1:0]   w_off;
  logic [3:0]        w_bytes;
  logic [2*NB-1:0]   w_mask;
  logic [ADDR_W-1:0] w_lo_addr;
  logic [ADDR_W-1:0] w_hi_addr;
  logic [2*XLEN-1:0] w_st_wide;
  logic [XLEN-1:0]   w_ld_wide;
  logic [XLEN-1:0]   w_ld_ext;

  assign w_off     = r_alu[OFFW-1:0];
  assign w_bytes   = 4'd1 << r_size;
  assign w_mask    = ((MASK_ONE << w_bytes) - MASK_ONE) << w_off;
  assign w_lo_addr = {r_alu[ADDR_W-1:OFFW], {OFFW{1'b0}}};
  assign w_hi_addr = w_lo_addr + ADDR_W'(NB);
  assign w_st_wide = {{XLEN{1'b0}}, r_data2} << {w_off, 3'b000};
  // Hi beat data is zero when unused, so the shifted pair works for single beats too.
  assign w_ld_wide = XLEN'({r_hi_rdata, r_lo_rdata} >> {w_off, 3'b000});

  always_comb begin
    int  nbits;
    logic sign;
    nbits = XLEN;
    sign  = 1'b0;
    case (r_size)
      2'd0:    begin nbits = 8;    sign = w_ld_wide[7];      end
      2'd1:    begin nbits = 16;   sign = w_ld_wide[15];     end
      2'd2:    begin nbits = 32;   sign = w_ld_wide[31];     end
      default: begin nbits = XLEN; sign = w_ld_wide[XLEN-1]; end
    endcase
    sign = sign & ~r_unsigned;
    for (int i = 0; i < int'(XLEN); i++) begin
      w_ld_ext[i] = (i < nbits) ? w_ld_wide[i] : sign;
    end
  end

  // Beat fields are driven only while a request is presented.
  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_addr_o  = '0;
    dmem_we_o    = '0;
    dmem_wdata_o = '0;
    case (r_state)
      REQ_LO: begin
        dmem_req_o   = 1'b1;
        dmem_addr_o  = w_lo_addr;
        dmem_we_o    = r_store ? w_mask[NB-1:0] : '0;
        dmem_wdata_o = r_store ? w_st_wide[XLEN-1:0] : '0;
      end
      REQ_HI: begin
        dmem_req_o   = 1'b1;
        dmem_addr_o  = w_hi_addr;
        dmem_we_o    = r_store ? w_mask[2*NB-1:NB] : '0;
        dmem_wdata_o = r_store ? w_st_wide[2*XLEN-1:XLEN] : '0;
      end
      default: ;
    endcase
  end

  assign req_ready_o = (r_state == IDLE);
  assign stall_o     = ~req_ready_o;
  assign wb_valid_o  = (r_state == RESP);
  assign wa_o        = r_wa;
  assign we_o        = r_we;
  assign fault_o     = r_fault;
  assign wdata_o     = r_load ? w_ld_ext : r_alu;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_load     <= 1'b0;
      r_store    <= 1'b0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_alu      <= '0;
      r_data2    <= '0;
      r_wa       <= '0;
      r_we       <= 1'b0;
      r_fault    <= 1'b0;
      r_need_hi  <= 1'b0;
      r_lo_rdata <= '0;
      r_hi_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_load     <= is_load_i;
            r_store    <= is_store_i & ~is_load_i;
            r_size     <= size_i;
            r_unsigned <= unsigned_i;
            r_alu      <= aluout_i;
            r_data2    <= data2_i;
            r_wa       <= wa_i;
            r_we       <= we_i & ~w_in_fault;
            r_fault    <= w_in_fault;
            r_need_hi  <= w_in_cross;
            r_lo_rdata <= '0;
            r_hi_rdata <= '0;
            r_state    <= (w_in_fault | ~w_in_mem) ? RESP : REQ_LO;
          end
        end
        REQ_LO: begin
          if (dmem_gnt_i) begin
            r_state <= r_load ? WAIT_LO : (r_need_hi ? REQ_HI : RESP);
          end
        end
        WAIT_LO: begin
          if (dmem_rvalid_i) begin
            r_lo_rdata <= dmem_rdata_i;
            r_state    <= r_need_hi ? REQ_HI : RESP;
          end
        end
        REQ_HI: begin
          if (dmem_gnt_i) begin
            r_state <= r_load ? WAIT_HI : RESP;
          end
        end
        WAIT_HI: begin
          if (dmem_rvalid_i) begin
            r_hi_rdata <= dmem_rdata_i;
            r_state    <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid1;
  logic        is_load, is_store, uns, we;
  logic [1:0]  size;
  logic [31:0] alu, d2;
  logic [4:0]  wa;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = 32'h0;

  logic        ready0, stall0, wbv0, we_o0, fault0, dreq0;
  logic [4:0]  wa_o0;
  logic [31:0] wdata0, daddr0, dwdata0;
  logic [3:0]  dwe0;

  logic        ready1, stall1, wbv1, we_o1, fault1, dreq1;
  logic [4:0]  wa_o1;
  logic [31:0] wdata1, daddr1, dwdata1;
  logic [3:0]  dwe1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.XLEN(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) dut0 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(ready0),
    .is_load_i(is_load), .is_store_i(is_store), .size_i(size), .unsigned_i(uns),
    .aluout_i(alu), .data2_i(d2), .wa_i(wa), .we_i(we), .stall_o(stall0),
    .wb_valid_o(wbv0), .wa_o(wa_o0), .we_o(we_o0), .wdata_o(wdata0), .fault_o(fault0),
    .dmem_req_o(dreq0), .dmem_gnt_i(gnt), .dmem_addr_o(daddr0), .dmem_we_o(dwe0),
    .dmem_wdata_o(dwdata0), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata)
  );

  lsu_mem_stage #(.XLEN(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b0)) dut1 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid1), .req_ready_o(ready1),
    .is_load_i(is_load), .is_store_i(is_store), .size_i(size), .unsigned_i(uns),
    .aluout_i(alu), .data2_i(d2), .wa_i(wa), .we_i(we), .stall_o(stall1),
    .wb_valid_o(wbv1), .wa_o(wa_o1), .we_o(we_o1), .wdata_o(wdata1), .fault_o(fault1),
    .dmem_req_o(dreq1), .dmem_gnt_i(zero1), .dmem_addr_o(daddr1), .dmem_we_o(dwe1),
    .dmem_wdata_o(dwdata1), .dmem_rvalid_i(zero1), .dmem_rdata_i(zero32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] w,
                       input logic e);
    is_load = ld; is_store = st; size = sz; uns = un; alu = a; d2 = d; wa = w; we = e;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  // Hold off the grant for 'delay' cycles, checking the beat stays stable, then grant.
  task automatic grant_beat(input string tag, input logic [31:0] ea, input logic [3:0] ewe,
                            input logic [31:0] ewd, input logic chk_wd, input int delay);
    for (int k = 0; k <= delay; k++) begin
      chk({tag, "_req"}, 64'(dreq0), 64'(1'b1));
      chk({tag, "_stall"}, 64'(stall0), 64'(1'b1));
      chk({tag, "_addr"}, 64'(daddr0), 64'(ea));
      chk({tag, "_we"}, 64'(dwe0), 64'(ewe));
      if (chk_wd) chk({tag, "_wdata"}, 64'(dwdata0), 64'(ewd));
      if (k == delay) gnt = 1'b1;
      step();
    end
    gnt = 1'b0;
  endtask

  task automatic respond(input string tag, input logic [31:0] rd);
    chk({tag, "_noreq"}, 64'(dreq0), 64'(1'b0));
    rvalid = 1'b1; rdata = rd;
    step();
    rvalid = 1'b0; rdata = '0;
  endtask

  task automatic expect_wb(input string tag, input logic [31:0] ewd, input logic chk_wd,
                           input logic ewe, input logic efault, input logic [4:0] ewa);
    chk({tag, "_wbv"}, 64'(wbv0), 64'(1'b1));
    chk({tag, "_stall"}, 64'(stall0), 64'(1'b1));
    chk({tag, "_weo"}, 64'(we_o0), 64'(ewe));
    chk({tag, "_fault"}, 64'(fault0), 64'(efault));
    chk({tag, "_wa"}, 64'(wa_o0), 64'(ewa));
    if (chk_wd) chk({tag, "_wdata"}, 64'(wdata0), 64'(ewd));
    step();
    chk({tag, "_wbv_low"}, 64'(wbv0), 64'(1'b0));
    chk({tag, "_ready"}, 64'(ready0), 64'(1'b1));
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_valid1 = 1'b0;
    is_load = 1'b0; is_store = 1'b0; size = 2'd0; uns = 1'b0; alu = '0; d2 = '0;
    wa = '0; we = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    step();
    step();
    // Reset values
    chk("rst_ready", 64'(ready0), 64'(1'b1));
    chk("rst_stall", 64'(stall0), 64'(1'b0));
    chk("rst_wbv", 64'(wbv0), 64'(1'b0));
    chk("rst_fault", 64'(fault0), 64'(1'b0));
    chk("rst_weo", 64'(we_o0), 64'(1'b0));
    chk("rst_wa", 64'(wa_o0), 64'(5'd0));
    chk("rst_wdata", 64'(wdata0), 64'(32'h0));
    chk("rst_dreq", 64'(dreq0), 64'(1'b0));
    chk("rst_dwe", 64'(dwe0), 64'(4'h0));
    chk("rst_daddr", 64'(daddr0), 64'(32'h0));
    chk("rst_dwdata", 64'(dwdata0), 64'(32'h0));
    chk("rst_ready1", 64'(ready1), 64'(1'b1));
    rst = 1'b0;
    step();

    // Aligned LW
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd5, 1'b1);
    chk("lw_ready_low", 64'(ready0), 64'(1'b0));
    grant_beat("lw", 32'h100, 4'b0000, 32'h0, 1'b0, 0);
    respond("lw", 32'hDEADBEEF);
    expect_wb("lw", 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 5'd5);

    // LB with sign extension, then LBU
    issue(1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd6, 1'b1);
    grant_beat("lb", 32'h100, 4'b0000, 32'h0, 1'b0, 0);
    respond("lb", 32'h80112233);
    expect_wb("lb", 32'hFFFFFF80, 1'b1, 1'b1, 1'b0, 5'd6);
    issue(1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 5'd7, 1'b1);
    grant_beat("lbu", 32'h100, 4'b0000, 32'h0, 1'b0, 0);
    respond("lbu", 32'h80112233);
    expect_wb("lbu", 32'h00000080, 1'b1, 1'b1, 1'b0, 5'd7);

    // SH into the upper half of a word
    issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 32'h0000ABCD, 5'd0, 1'b0);
    grant_beat("sh", 32'h100, 4'b1100, 32'hABCD0000, 1'b1, 0);
    expect_wb("sh", 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);

    // Misaligned LW split into two beats
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h103, 32'h0, 5'd9, 1'b1);
    grant_beat("mlw_lo", 32'h100, 4'b0000, 32'h0, 1'b0, 0);
    respond("mlw_lo", 32'h44332211);
    grant_beat("mlw_hi", 32'h104, 4'b0000, 32'h0, 1'b0, 0);
    respond("mlw_hi", 32'h88776655);
    expect_wb("mlw", 32'h77665544, 1'b1, 1'b1, 1'b0, 5'd9);

    // Same access without splitting faults immediately with no memory request
    is_load = 1'b1; is_store = 1'b0; size = 2'd2; uns = 1'b0; alu = 32'h103; wa = 5'd9;
    we = 1'b1;
    req_valid1 = 1'b1;
    step();
    req_valid1 = 1'b0;
    chk("nosplit_wbv", 64'(wbv1), 64'(1'b1));
    chk("nosplit_fault", 64'(fault1), 64'(1'b1));
    chk("nosplit_weo", 64'(we_o1), 64'(1'b0));
    chk("nosplit_dreq", 64'(dreq1), 64'(1'b0));
    step();
    chk("nosplit_wbv_low", 64'(wbv1), 64'(1'b0));
    chk("nosplit_ready", 64'(ready1), 64'(1'b1));
    chk("nosplit_dreq2", 64'(dreq1), 64'(1'b0));

    // Misaligned SW with a 3-cycle grant delay per beat
    issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h0FE, 32'h11223344, 5'd0, 1'b0);
    grant_beat("msw_lo", 32'h0FC, 4'b1100, 32'h33440000, 1'b1, 3);
    grant_beat("msw_hi", 32'h100, 4'b0011, 32'h00001122, 1'b1, 3);
    expect_wb("msw", 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);

    // Non-memory pass-through completes in one cycle
    issue(1'b0, 1'b0, 2'd0, 1'b0, 32'hCAFEF00D, 32'h0, 5'd12, 1'b1);
    expect_wb("alu", 32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 5'd12);

    // Doubleword on a 32-bit datapath is an illegal size
    issue(1'b1, 1'b0, 2'd3, 1'b0, 32'h200, 32'h0, 5'd3, 1'b1);
    chk("ill_dreq", 64'(dreq0), 64'(1'b0));
    expect_wb("ill", 32'h0, 1'b0, 1'b0, 1'b1, 5'd3);

    // Reset while waiting for the lo response
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 5'd4, 1'b1);
    grant_beat("abort", 32'h200, 4'b0000, 32'h0, 1'b0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_dreq", 64'(dreq0), 64'(1'b0));
    chk("abort_stall", 64'(stall0), 64'(1'b0));
    chk("abort_ready", 64'(ready0), 64'(1'b1));
    chk("abort_wbv", 64'(wbv0), 64'(1'b0));
    chk("abort_wa", 64'(wa_o0), 64'(5'd0));
    rvalid = 1'b1; rdata = 32'h55555555;
    step();
    rvalid = 1'b0; rdata = '0;
    chk("stray_wbv", 64'(wbv0), 64'(1'b0));
    chk("stray_ready", 64'(ready0), 64'(1'b1));
    step();
    chk("stray_wbv2", 64'(wbv0), 64'(1'b0));
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 5'd8, 1'b1);
    grant_beat("post", 32'h104, 4'b0000, 32'h0, 1'b0, 0);
    respond("post", 32'h12345678);
    expect_wb("post", 32'h12345678, 1'b1, 1'b1, 1'b0, 5'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
